// File: rtl/lc3_tb_pkg.sv
// Shared types and constants for the LC3 instruction-memory responder.
package lc3_tb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    // BR with no condition bits set never branches, so it doubles as a NOP.
    localparam logic [15:0] NOP_WORD          = 16'h0000;
    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h3000;

endpackage

// File: rtl/lc3_prog_store.sv
// Program store: synchronous write, combinational read with write-first bypass.
module lc3_prog_store #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Store write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (load_en) begin
            mem_r[load_addr] <= load_data;
        end
    end

    // Read port returns data being written this cycle to the same word.
    always_comb begin
        if (load_en && (load_addr == rd_addr)) begin
            rd_data = load_data;
        end else begin
            rd_data = mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/lc3_imem_responder.sv
// LC3 fetch-port responder: programmable wait states, out-of-range flagging
// and a completed-fetch counter in front of a loadable program store.
module lc3_imem_responder
    import lc3_tb_pkg::*;
#(
    parameter int              ADDR_W    = 16,
    parameter int              DATA_W    = 16,
    parameter int              DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter int              LAT_W     = 3,
    localparam int             IDX_W     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [LAT_W-1:0]  lat_cfg,
    input  logic [ADDR_W-1:0] pc,
    input  logic              instrmem_rd,
    output logic [DATA_W-1:0] Instr_dout,
    output logic              complete_instr,
    output logic              oob_err,
    output logic [31:0]       fetch_count
);

    resp_state_e       state_r;
    resp_state_e       state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [LAT_W-1:0]  cnt_r;
    logic [LAT_W-1:0]  cnt_nxt_s;
    logic              capture_s;
    logic              strobe_s;
    logic [ADDR_W-1:0] offset_s;
    logic              oob_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic [DATA_W-1:0] rd_data_s;

    // Offset wraps modulo 2**ADDR_W, so pc below BASE_ADDR lands out of range.
    assign offset_s = pc_r - BASE_ADDR;
    assign oob_s    = (32'(offset_s) >= 32'(DEPTH));
    assign rd_idx_s = offset_s[IDX_W-1:0];

    lc3_prog_store #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_store (
        .clock     (clock),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .rd_addr   (rd_idx_s),
        .rd_data   (rd_data_s)
    );

    // Next-state logic; a new request may be captured in IDLE or back-to-back in RESP.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        cnt_nxt_s   = cnt_r;
        capture_s   = 1'b0;
        strobe_s    = 1'b0;

        case (state_r)
            IDLE: begin
                if (instrmem_rd) begin
                    capture_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (!instrmem_rd) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {LAT_W{1'b0}};
                end else if (cnt_r <= LAT_W'(1)) begin
                    state_nxt_s = RESP;
                    cnt_nxt_s   = {LAT_W{1'b0}};
                end else begin
                    cnt_nxt_s   = cnt_r - LAT_W'(1);
                end
            end
            RESP: begin
                strobe_s = 1'b1;
                if (instrmem_rd) begin
                    capture_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {LAT_W{1'b0}};
            end
        endcase

        if (capture_s) begin
            pc_nxt_s = pc;
            if (lat_cfg == {LAT_W{1'b0}}) begin
                state_nxt_s = RESP;
                cnt_nxt_s   = {LAT_W{1'b0}};
            end else begin
                state_nxt_s = WAIT;
                cnt_nxt_s   = lat_cfg;
            end
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // FSM state, captured address and wait counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            pc_r    <= {ADDR_W{1'b0}};
            cnt_r   <= {LAT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Response outputs; Instr_dout holds between strobes and oob_err is sticky.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Instr_dout     <= {DATA_W{1'b0}};
            complete_instr <= 1'b0;
            oob_err        <= 1'b0;
            fetch_count    <= 32'd0;
        end else if (strobe_s) begin
            Instr_dout     <= oob_s ? DATA_W'(NOP_WORD) : rd_data_s;
            complete_instr <= 1'b1;
            oob_err        <= oob_err | oob_s;
            fetch_count    <= fetch_count + 32'd1;
        end else begin
            complete_instr <= 1'b0;
        end
    end

endmodule
